// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module  : alu_exec_unit
// Brief   : Parametrised execute unit. Register file with two read ports and an
//           external write port, ALU with {C,L,F,Z,N} flag register, and a
//           shift-add multiplier. Ops are accepted through a valid/ready handshake.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module alu_exec_unit #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        op,
  input  logic [AW-1:0]     rdst,
  input  logic [AW-1:0]     rsrc,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_sel,
  input  logic              ext_wr_en,
  input  logic [AW-1:0]     ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  input  logic [AW-1:0]     dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic [4:0]        flags,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0]   c_last_cnt = CW'(DATA_W - 1);
  localparam logic [DATA_W:0] c_sh_lim   = (DATA_W + 1)'(DATA_W);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_CMP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  // Flag bit positions within {C,L,F,Z,N}
  localparam int FC = 4;
  localparam int FL = 3;
  localparam int FF = 2;
  localparam int FZ = 1;
  localparam int FN = 0;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [4:0]          flags_q, flags_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   mul_acc_q, mul_acc_d;
  logic [DATA_W-1:0]   mul_mcand_q, mul_mcand_d;
  logic [DATA_W-1:0]   mul_mplier_q, mul_mplier_d;
  logic [CW-1:0]       mul_cnt_q, mul_cnt_d;
  logic [AW-1:0]       mul_dst_q, mul_dst_d;

  logic                w_accept;
  logic [DATA_W-1:0]   w_opa, w_opb;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic                w_sh_neg;
  logic [DATA_W:0]     w_sh_mag;
  logic [DATA_W-1:0]   w_lsh;
  logic [DATA_W-1:0]   w_mul_acc_nxt;
  logic                w_wb_en;
  logic [AW-1:0]       w_wb_addr;
  logic [DATA_W-1:0]   w_wb_data;

  assign issue_ready = (state_q == S_IDLE) & ~reset;
  assign w_accept    = issue_valid & issue_ready;
  assign busy        = (state_q == S_MUL);
  assign done        = done_q;
  assign flags       = flags_q;
  assign dbg_rd_data = regs_q[dbg_rd_addr];

  assign w_opa  = regs_q[rdst];
  assign w_opb  = imm_sel ? imm : regs_q[rsrc];
  assign w_sum  = {1'b0, w_opa} + {1'b0, w_opb};
  assign w_diff = w_opa - w_opb;

  // Shift amount is signed; magnitude is one bit wider so the most negative
  // value still yields a correct (out-of-range) magnitude.
  assign w_sh_neg = w_opb[DATA_W-1];
  assign w_sh_mag = w_sh_neg ? ({1'b0, ~w_opb} + 1'b1) : {1'b0, w_opb};
  assign w_lsh    = (w_sh_mag >= c_sh_lim) ? '0 :
                    (w_sh_neg ? (w_opa >> w_sh_mag) : (w_opa << w_sh_mag));

  assign w_mul_acc_nxt = mul_mplier_q[0] ? (mul_acc_q + mul_mcand_q) : mul_acc_q;

  // Next-state, flag, writeback and multiplier datapath decode
  always_comb begin
    state_d      = state_q;
    flags_d      = flags_q;
    done_d       = 1'b0;
    mul_acc_d    = mul_acc_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    mul_cnt_d    = mul_cnt_q;
    mul_dst_d    = mul_dst_q;
    w_wb_en      = 1'b0;
    w_wb_addr    = rdst;
    w_wb_data    = '0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          done_d = 1'b1;
          case (op)
            OP_ADD: begin
              w_wb_en     = 1'b1;
              w_wb_data   = w_sum[DATA_W-1:0];
              flags_d[FC] = w_sum[DATA_W];
              flags_d[FF] = (w_opa[DATA_W-1] == w_opb[DATA_W-1]) &
                            (w_sum[DATA_W-1] != w_opa[DATA_W-1]);
              flags_d[FZ] = (w_sum[DATA_W-1:0] == '0);
              flags_d[FN] = w_sum[DATA_W-1];
            end
            OP_SUB, OP_CMP: begin
              w_wb_en     = (op == OP_SUB);
              w_wb_data   = w_diff;
              flags_d[FC] = (w_opa < w_opb);
              flags_d[FL] = (w_opa < w_opb);
              flags_d[FF] = (w_opa[DATA_W-1] != w_opb[DATA_W-1]) &
                            (w_diff[DATA_W-1] != w_opa[DATA_W-1]);
              flags_d[FZ] = (w_opa == w_opb);
              flags_d[FN] = ($signed(w_opa) < $signed(w_opb));
            end
            OP_AND: begin w_wb_en = 1'b1; w_wb_data = w_opa & w_opb; end
            OP_OR:  begin w_wb_en = 1'b1; w_wb_data = w_opa | w_opb; end
            OP_XOR: begin w_wb_en = 1'b1; w_wb_data = w_opa ^ w_opb; end
            OP_MOV: begin w_wb_en = 1'b1; w_wb_data = w_opb; end
            OP_LSH: begin w_wb_en = 1'b1; w_wb_data = w_lsh; end
            OP_MUL: begin
              done_d       = 1'b0;
              state_d      = S_MUL;
              mul_acc_d    = '0;
              mul_mcand_d  = w_opa;
              mul_mplier_d = w_opb;
              mul_cnt_d    = '0;
              mul_dst_d    = rdst;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        mul_acc_d    = w_mul_acc_nxt;
        mul_mcand_d  = {mul_mcand_q[DATA_W-2:0], 1'b0};
        mul_mplier_d = {1'b0, mul_mplier_q[DATA_W-1:1]};
        mul_cnt_d    = mul_cnt_q + 1'b1;
        if (mul_cnt_q == c_last_cnt) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          w_wb_en     = 1'b1;
          w_wb_addr   = mul_dst_q;
          w_wb_data   = w_mul_acc_nxt;
          flags_d[FZ] = (w_mul_acc_nxt == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, flag and multiplier registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      flags_q      <= '0;
      done_q       <= 1'b0;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
      mul_dst_q    <= '0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      done_q       <= done_d;
      mul_acc_q    <= mul_acc_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      mul_cnt_q    <= mul_cnt_d;
      mul_dst_q    <= mul_dst_d;
    end
  end

  // Register file: the unit's own writeback is assigned last so it wins a
  // same-register collision with the external port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (ext_wr_en) regs_q[ext_wr_addr] <= ext_wr_data;
      if (w_wb_en)   regs_q[w_wb_addr]   <= w_wb_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_exec_unit
// Brief   : Self-checking bench for alu_exec_unit (DATA_W=16, NUM_REGS=16).
//           An arithmetic reference model is compared every cycle, plus
//           hand-computed literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  op = 4'd0;
  logic [3:0]  rdst = 4'd0;
  logic [3:0]  rsrc = 4'd0;
  logic [15:0] imm = 16'd0;
  logic        imm_sel = 1'b0;
  logic        ext_wr_en = 1'b0;
  logic [3:0]  ext_wr_addr = 4'd0;
  logic [15:0] ext_wr_data = 16'd0;
  logic [3:0]  dbg_rd_addr = 4'd0;
  logic [15:0] dbg_rd_data;
  logic [4:0]  flags;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_W(16), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op(op), .rdst(rdst), .rsrc(rsrc), .imm(imm), .imm_sel(imm_sel),
    .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data),
    .flags(flags), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [15:0] m_regs [16];
  logic [4:0]  m_flags = 5'd0;
  int          m_left  = 0;
  logic [15:0] m_res   = 16'd0;
  logic [3:0]  m_dst   = 4'd0;
  bit          m_done  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int to_signed(input longint unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  // Model of one clock edge, computed from the inputs currently applied
  task automatic model_update();
    longint unsigned a, b, s;
    int sa, sb;
    bit nd;
    logic [15:0] r;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;
      m_flags = 5'd0; m_left = 0; m_done = 1'b0;
      return;
    end
    a  = m_regs[rdst];
    b  = imm_sel ? imm : m_regs[rsrc];
    sa = to_signed(a);
    sb = to_signed(b);
    nd = 1'b0;
    if (ext_wr_en) m_regs[ext_wr_addr] = ext_wr_data;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_regs[m_dst] = m_res;
        m_flags[1] = (m_res == 16'd0);
        nd = 1'b1;
      end
    end else if (issue_valid) begin
      nd = 1'b1;
      case (op)
        4'd0: begin
          s = a + b; r = 16'(s);
          m_flags[4] = (s > 65535);
          m_flags[2] = (sa + sb > 32767) || (sa + sb < -32768);
          m_flags[1] = (r == 16'd0);
          m_flags[0] = r[15];
          m_regs[rdst] = r;
        end
        4'd1, 4'd2: begin
          r = 16'(a - b);
          m_flags[4] = (a < b);
          m_flags[3] = (a < b);
          m_flags[2] = (sa - sb > 32767) || (sa - sb < -32768);
          m_flags[1] = (a == b);
          m_flags[0] = (sa < sb);
          if (op == 4'd1) m_regs[rdst] = r;
        end
        4'd3: m_regs[rdst] = 16'(a & b);
        4'd4: m_regs[rdst] = 16'(a | b);
        4'd5: m_regs[rdst] = 16'(a ^ b);
        4'd6: m_regs[rdst] = 16'(b);
        4'd7: begin
          if (sb >= 16 || sb <= -16) r = 16'd0;
          else if (sb >= 0)          r = 16'(a << sb);
          else                       r = 16'(a >> (-sb));
          m_regs[rdst] = r;
        end
        4'd8: begin
          nd = 1'b0; m_left = 16; m_res = 16'(a * b); m_dst = rdst;
        end
        default: ;
      endcase
    end
    m_done = nd;
  endtask

  // One clock: compare DUT against model mid-cycle, advance model, drive after edge
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      check("ready", issue_ready, (m_left == 0) && !reset);
      check("busy",  busy,  m_left != 0);
      check("done",  done,  m_done);
      check("flags", flags, m_flags);
      check("dbg_rd_data", dbg_rd_data, m_regs[dbg_rd_addr]);
    end
    model_update();
    @(posedge clk);
    #1;
    dbg_rd_addr = dbg_rd_addr + 4'd1;
  endtask

  task automatic ext_wr(input logic [3:0] a, input logic [15:0] d);
    ext_wr_en = 1'b1; ext_wr_addr = a; ext_wr_data = d;
    step();
    ext_wr_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [3:0] d, input logic [3:0] s,
                       input logic [15:0] im, input logic sel);
    op = o; rdst = d; rsrc = s; imm = im; imm_sel = sel; issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [15:0] exp);
    dbg_rd_addr = a;
    #1;
    check(name, dbg_rd_data, exp);
  endtask

  initial begin
    int n, nready0;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;

    // Reset for two cycles
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_ready", issue_ready, 1'b1);
    check("rst_busy",  busy,  1'b0);
    check("rst_done",  done,  1'b0);
    check("rst_flags", flags, 5'b00000);
    for (int i = 0; i < 16; i++) rd("rst_reg", 4'(i), 16'h0000);

    // ADD with signed overflow
    ext_wr(4'd1, 16'h7FFF);
    ext_wr(4'd2, 16'h0001);
    issue(4'd0, 4'd1, 4'd2, 16'h0, 1'b0);
    check("add_done_next", done, 1'b1);
    check("add_flags", flags, 5'b00101);
    rd("add_r1", 4'd1, 16'h8000);

    // CMP equal, then CMP against 0xFFFF
    ext_wr(4'd3, 16'h0005);
    issue(4'd2, 4'd3, 4'd0, 16'h0005, 1'b1);
    check("cmp_eq_flags", flags, 5'b00010);
    rd("cmp_r3", 4'd3, 16'h0005);
    issue(4'd2, 4'd3, 4'd0, 16'hFFFF, 1'b1);
    check("cmp_lt_flags", flags, 5'b11000);

    // MUL with zero low half
    ext_wr(4'd4, 16'h0100);
    ext_wr(4'd5, 16'h0300);
    issue(4'd8, 4'd4, 4'd5, 16'h0, 1'b0);
    n = 0; nready0 = 0;
    while (n < 40) begin
      if (!issue_ready) nready0++;
      if (done) break;
      step(); n++;
    end
    check("mul_done_latency", n, 16);
    check("mul_not_ready_cycles", nready0, 16);
    rd("mul_r4", 4'd4, 16'h0000);
    check("mul_z_flags", flags, 5'b11010);

    // MUL by immediate, ext write to rdst mid-MUL, OR held while busy
    ext_wr(4'd6, 16'h00F0);
    issue(4'd8, 4'd6, 4'd0, 16'h0003, 1'b1);
    step();
    ext_wr(4'd6, 16'hAAAA);
    op = 4'd4; rdst = 4'd8; rsrc = 4'd6; imm_sel = 1'b0; issue_valid = 1'b1;
    n = 0;
    while (!done && n < 40) begin step(); n++; end
    check("mul2_done_seen", done, 1'b1);
    rd("mul2_r6", 4'd6, 16'h02D0);
    check("mul2_flags", flags, 5'b11000);
    step();
    issue_valid = 1'b0;
    step();
    rd("held_or_r8", 4'd8, 16'h02D0);

    // Rerun MUL, reset mid-way
    issue(4'd8, 4'd6, 4'd0, 16'h0003, 1'b1);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("abort_ready", issue_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    rd("abort_r6", 4'd6, 16'h0000);
    for (int i = 0; i < 20; i++) step();

    // LSH right by one, then by 16
    ext_wr(4'd7, 16'h8001);
    issue(4'd7, 4'd7, 4'd0, 16'hFFFF, 1'b1);
    rd("lsh_right", 4'd7, 16'h4000);
    issue(4'd7, 4'd7, 4'd0, 16'h0010, 1'b1);
    rd("lsh_16", 4'd7, 16'h0000);
    ext_wr(4'd7, 16'h0003);
    issue(4'd7, 4'd7, 4'd0, 16'h0002, 1'b1);
    rd("lsh_left", 4'd7, 16'h000C);

    // Same-edge ext + ALU write: ALU value kept
    ext_wr_en = 1'b1; ext_wr_addr = 4'd7; ext_wr_data = 16'h1234;
    issue(4'd0, 4'd7, 4'd0, 16'h0001, 1'b1);
    ext_wr_en = 1'b0;
    rd("collide_r7", 4'd7, 16'h000D);

    // Different registers in the same edge: both written
    ext_wr_en = 1'b1; ext_wr_addr = 4'd9; ext_wr_data = 16'hBEEF;
    issue(4'd1, 4'd7, 4'd0, 16'h000E, 1'b1);
    ext_wr_en = 1'b0;
    rd("both_r7", 4'd7, 16'hFFFF);
    rd("both_r9", 4'd9, 16'hBEEF);
    check("sub_neg_flags", flags, 5'b11001);

    // Logic ops, MOV and a NOP
    issue(4'd6, 4'd10, 4'd9, 16'h0, 1'b0);
    rd("mov_r10", 4'd10, 16'hBEEF);
    issue(4'd3, 4'd10, 4'd0, 16'h0FF0, 1'b1);
    rd("and_r10", 4'd10, 16'h0EE0);
    issue(4'd5, 4'd10, 4'd9, 16'h0, 1'b0);
    rd("xor_r10", 4'd10, 16'hB00F);
    issue(4'd12, 4'd10, 4'd0, 16'h1111, 1'b1);
    check("nop_done", done, 1'b1);
    rd("nop_r10", 4'd10, 16'hB00F);

    for (int i = 0; i < 20; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
